mips8_controller: RTL and testbench
===================================

Name: mips8_controller

Overview:
- Multicycle control FSM driving the 8-bit MIPS datapath; the datapath consumes every control strobe produced here.
- Takes op/funct from the datapath's instruction register and the ALU zero flag.
- Produces per-cycle control for byte-wise fetch, decode, execute, memory and writeback, plus an internal ALU decoder for alucontrol.

Parameters:
- STATE_W, 4, width of the debug state output and the state register.
- ILLEGAL_TRAP, 0: 0 = illegal opcode returns to FETCH1; 1 = illegal opcode parks in HALT until reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from datapath.
- funct  in  6  instr[5:0] from datapath.
- zero  in  1  ALU zero flag.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 1, 10 = imm, 11 = imm (branch offset).
- memtoreg  out  1  register write data from MDR.
- regdst  out  1  1 = rd, 0 = rt.
- iord  out  1  1 = address from ALUOut.
- pcen  out  1  PC load enable.
- regwrite  out  1  register file write.
- pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump.
- irwrite  out  4  one-hot IR byte-lane load.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  STATE_W  current state (debug).

Behaviour:
Reset and timing
- While reset=0: state=FETCH1 and all control outputs forced to 0, including irwrite=0000 and alucontrol=000.
- Reset is asynchronous at assertion and mid-instruction; the first active cycle after release is FETCH1.
- Outputs are Moore decodes of state, except that pcen and alucontrol also depend on zero and funct in the same cycle.
- Unlisted outputs are 0 in every state.
- pcen = pcwrite | (branch & zero).

States and outputs
- FETCH1..FETCH4: memread=1; irwrite=0001/0010/0100/1000 respectively; alusrca=0; alusrcb=01; alucontrol=010; pcsrc=00; pcwrite=1. Sequential advance.
- DECODE: alusrcb=11, alucontrol=010. Next state by op:
  - 100000 (lb) or 101000 (sb) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 000010 -> JEX
  - 001000 -> ADDIEX (only with the optional feature)
  - any other op -> FETCH1, or HALT when ILLEGAL_TRAP=1
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010; next state LBRD for lb, SBWR for sb.
- LBRD: memread=1, iord=1 -> LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
- SBWR: memwrite=1, iord=1 -> FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00; funct 100000/100010/100100/100101/101010 -> 010/110/000/001/111; other funct -> 010 -> RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1 -> FETCH1.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, branch=1, pcsrc=01 -> FETCH1.
- JEX: pcwrite=1, pcsrc=10 -> FETCH1.
- HALT: all outputs 0; self-loop until reset.

Cycle counts
- lb 8, sb 7, R-type 7, beq 6, j 6 cycles.
- Unused state encodings -> FETCH1 on the next edge.

Optional Feature:
- Macro: CTRL_ADDI_EN.
- Defined: op 001000 decodes to ADDIEX (alusrca=1, alusrcb=10, alucontrol=010), then ADDIWR (regwrite=1, regdst=0, memtoreg=0), then FETCH1; addi takes 7 cycles.
- Undefined: op 001000 is illegal and follows the ILLEGAL_TRAP rule; ADDIEX/ADDIWR are not synthesized.

Test Plan:
- Reset low for 2 cycles, then release with op=100000 -> FETCH1..FETCH4 irwrite 0001, 0010, 0100, 1000 with pcen=1 each cycle; then MEMADR, LBRD (memread=1, iord=1), LBWR (regwrite=1, memtoreg=1); FETCH1 at cycle 9.
- op=0, funct=100010 -> RTYPEEX alucontrol=110, then RTYPEWR regwrite=1, regdst=1; op=0, funct=101010 -> alucontrol=111.
- op=000100: zero=1 in BEQEX -> pcen=1, pcsrc=01; zero=0 -> pcen=0; both cases return to FETCH1.
- op=000010 -> JEX pcen=1, pcsrc=10; op=101000 -> SBWR memwrite=1, iord=1, regwrite=0.
- op=111111 with ILLEGAL_TRAP=0 -> FETCH1 after DECODE; with ILLEGAL_TRAP=1 -> HALT with all outputs 0 until reset.
- Assert reset low mid-LBRD -> outputs go 0 immediately with no clock edge; restart in FETCH1. With CTRL_ADDI_EN, op=001000 -> ADDIEX then ADDIWR regwrite=1, regdst=0.

Source files
------------

// File: rtl/mips8_controller.sv
// mips8_controller: multicycle control FSM for the 8-bit MIPS datapath.
// Fetches the instruction one byte lane per cycle, then decodes and
// sequences the execute, memory and writeback steps. It also contains the
// ALU decoder that drives alucontrol.
// Optional feature: define CTRL_ADDI_EN to add the addi instruction
// (ADDIEX/ADDIWR states).
// ILLEGAL_TRAP=1 parks an illegal opcode in HALT until reset.
// Reset is asynchronous and active-low. While reset is low, every control
// output is also gated to 0 combinationally.
module mips8_controller #(
  parameter int unsigned STATE_W      = 4,
  parameter bit          ILLEGAL_TRAP = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               memread,
  output logic               memwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               memtoreg,
  output logic               regdst,
  output logic               iord,
  output logic               pcen,
  output logic               regwrite,
  output logic [1:0]         pcsrc,
  output logic [3:0]         irwrite,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
    SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR, HALT
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t cur, nxt;
  logic   pcwrite, branch;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= FETCH1;
    else        cur <= nxt;
  end

  // Next-state logic and control decode. Outputs are gated to 0 while reset is held.
  always_comb begin
    nxt        = FETCH1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    regwrite   = 1'b0;
    pcsrc      = 2'b00;
    irwrite    = 4'b0000;
    alucontrol = 3'b000;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcen       = 1'b0;
    case (cur)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        pcwrite    = 1'b1;
        case (cur)
          FETCH1:  begin irwrite = 4'b0001; nxt = FETCH2; end
          FETCH2:  begin irwrite = 4'b0010; nxt = FETCH3; end
          FETCH3:  begin irwrite = 4'b0100; nxt = FETCH4; end
          default: begin irwrite = 4'b1000; nxt = DECODE; end
        endcase
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LB, OP_SB: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_J:         nxt = JEX;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      nxt = ADDIEX;
`endif
          default:      nxt = ILLEGAL_TRAP ? HALT : FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        nxt        = (op == OP_SB) ? SBWR : LBRD;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        nxt     = LBWR;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        nxt      = FETCH1;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        nxt      = FETCH1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
        nxt = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        nxt      = FETCH1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        nxt        = FETCH1;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        nxt     = FETCH1;
      end
`ifdef CTRL_ADDI_EN
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        nxt        = ADDIWR;
      end
      ADDIWR: begin
        regwrite = 1'b1;
        nxt      = FETCH1;
      end
`endif
      HALT:    nxt = HALT;
      default: nxt = FETCH1;
    endcase
    pcen = pcwrite | (branch & zero);
    if (!reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      iord       = 1'b0;
      regwrite   = 1'b0;
      pcsrc      = 2'b00;
      irwrite    = 4'b0000;
      alucontrol = 3'b000;
      pcen       = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_mips8_controller.sv
// tb_mips8_controller: randomized instruction stream checked against a
// per-instruction table of expected control vectors. Also contains directed
// checks for reset, the HALT trap, a mid-instruction reset and instruction
// lengths.
module tb_mips8_controller;

  logic       clk = 1'b0;
  logic       reset, reset_t;
  logic [5:0] op, op_t, funct;
  logic       zero;

  logic memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic t_memread, t_memwrite, t_alusrca, t_memtoreg, t_regdst, t_iord, t_pcen, t_regwrite;
  logic [1:0] t_alusrcb, t_pcsrc;
  logic [3:0] t_irwrite;
  logic [2:0] t_alucontrol;
  logic [3:0] t_state;

  always #5 clk = ~clk;

  mips8_controller #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcen(pcen),
    .regwrite(regwrite), .pcsrc(pcsrc), .irwrite(irwrite),
    .alucontrol(alucontrol), .state(state)
  );

  mips8_controller #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) dut_t (
    .clk(clk), .reset(reset_t), .op(op_t), .funct(funct), .zero(zero),
    .memread(t_memread), .memwrite(t_memwrite), .alusrca(t_alusrca), .alusrcb(t_alusrcb),
    .memtoreg(t_memtoreg), .regdst(t_regdst), .iord(t_iord), .pcen(t_pcen),
    .regwrite(t_regwrite), .pcsrc(t_pcsrc), .irwrite(t_irwrite),
    .alucontrol(t_alucontrol), .state(t_state)
  );

  // Packed view: {memread,memwrite,alusrca,alusrcb,memtoreg,regdst,iord,pcen,regwrite,pcsrc,irwrite,alucontrol}
  logic [18:0] vec, vec_t;
  assign vec   = {memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord, pcen,
                  regwrite, pcsrc, irwrite, alucontrol};
  assign vec_t = {t_memread, t_memwrite, t_alusrca, t_alusrcb, t_memtoreg, t_regdst, t_iord,
                  t_pcen, t_regwrite, t_pcsrc, t_irwrite, t_alucontrol};

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic mr, mw, sa, input logic [1:0] sb,
                                     input logic mtr, rd, io, pe, rw, input logic [1:0] ps,
                                     input logic [3:0] ir, input logic [2:0] ac);
    return {mr, mw, sa, sb, mtr, rd, io, pe, rw, ps, ir, ac};
  endfunction

  function automatic logic [18:0] v_fetch(input int k);
    logic [3:0] lane;
    lane = 4'b0001 << k;
    return mk(1, 0, 0, 2'b01, 0, 0, 0, 1, 0, 2'b00, lane, 3'b010);
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  localparam logic [18:0] V_DECODE = {1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_ADDR   = {1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b010};
  localparam logic [18:0] V_LBRD   = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] V_LBWR   = {1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] V_SBWR   = {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] V_RTWR   = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] V_BEQ    = {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 3'b110};
  localparam logic [18:0] V_JEX    = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 3'b000};
  localparam logic [18:0] V_ADDIWR = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] PCEN_BIT = 19'd1 << 10;

  typedef struct packed { logic [18:0] v; logic beq; } step_t;
  step_t q[$];
  logic run = 1'b0;
  int   clen = 0;
  int   plen = 0;
  int   cyc  = 0;

  // Zero flag toggles randomly every cycle.
  initial begin
    zero = 1'b0;
    forever begin
      @(posedge clk);
      #1 zero = 1'($urandom);
    end
  end

  // Compare process: pops one expected step per cycle and checks instruction lengths.
  always @(negedge clk) begin
    if (!run) begin
      plen = 0;
    end else if (reset) begin
      if (vec[6:3] == 4'b0001) begin
        if (plen != 0) begin
          nchk++;
          if (cyc != plen) begin
            nerr++;
            $display("FAIL instr_len: got %0d want %0d cycles", cyc, plen);
          end
        end
        plen = clen;
        cyc  = 0;
      end
      cyc++;
      if (q.size() == 0) begin
        chk("queue_underflow", vec, 19'h7ffff);
      end else begin
        step_t s;
        logic [18:0] e;
        s = q.pop_front();
        e = s.v | ((s.beq && zero) ? PCEN_BIT : 19'd0);
        chk("step", vec, e);
      end
    end
  end

  task automatic wait_empty();
    int g = 0;
    while (q.size() != 0 && g < 40) begin
      @(posedge clk);
      g++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 19'd0, 19'h7ffff);
      q.delete();
    end
  endtask

  task automatic push(input logic [18:0] v, input logic b);
    step_t s;
    s.v = v;
    s.beq = b;
    q.push_back(s);
  endtask

  // Issues one instruction starting in FETCH1 and queues its expected control steps.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    wait_empty();
    #1;
    op = o;
    funct = f;
    for (int k = 0; k < 4; k++) push(v_fetch(k), 1'b0);
    push(V_DECODE, 1'b0);
    case (o)
      6'b100000: begin push(V_ADDR, 0); push(V_LBRD, 0); push(V_LBWR, 0); clen = 8; end
      6'b101000: begin push(V_ADDR, 0); push(V_SBWR, 0); clen = 7; end
      6'b000000: begin
        push(mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'b0000, alu_of(f)), 0);
        push(V_RTWR, 0);
        clen = 7;
      end
      6'b000100: begin push(V_BEQ, 1'b1); clen = 6; end
      6'b000010: begin push(V_JEX, 0); clen = 6; end
`ifdef CTRL_ADDI_EN
      6'b001000: begin push(V_ADDR, 0); push(V_ADDIWR, 0); clen = 7; end
`endif
      default: clen = 5;
    endcase
  endtask

  logic [5:0] ops [7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100,
                          6'b000010, 6'b001000, 6'b111111};
  logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b101010, 6'b000111};

  initial begin
    reset = 1'b0;
    reset_t = 1'b0;
    op = 6'b100000;
    op_t = 6'b111111;
    funct = 6'b0;

    // Outputs held at zero during reset.
    repeat (2) begin
      @(negedge clk);
      chk("reset_main", vec, 19'd0);
      chk("reset_trap", vec_t, 19'd0);
    end

    // An illegal opcode with trapping enabled fetches, decodes, then parks in HALT.
    @(posedge clk);
    #1 reset_t = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 4)       chk("trap_fetch", vec_t, v_fetch(k));
      else if (k == 4) chk("trap_decode", vec_t, V_DECODE);
      else             chk("trap_halt", vec_t, 19'd0);
      chk("main_in_reset", vec, 19'd0);
    end
    reset_t = 1'b0;
    @(posedge clk);
    #1 reset_t = 1'b1;
    @(negedge clk);
    chk("trap_restart", vec_t, mk(1, 0, 0, 2'b01, 0, 0, 0, 1, 0, 2'b00, 4'b0001, 3'b010));

    // Main DUT: release reset in FETCH1, then run directed and random instructions.
    @(posedge clk);
    #1 reset = 1'b1;
    run = 1'b1;
    run_instr(6'b100000, 6'b0);
    run_instr(6'b000000, 6'b100010);
    run_instr(6'b000000, 6'b101010);
    run_instr(6'b000100, 6'b0);
    run_instr(6'b000100, 6'b0);
    run_instr(6'b000010, 6'b0);
    run_instr(6'b101000, 6'b0);
    run_instr(6'b111111, 6'b0);
    run_instr(6'b001000, 6'b0);
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      f = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(o, f);
    end
    wait_empty();
    run = 1'b0;

    // Asynchronous reset during LBRD: outputs drop without a clock edge.
    #1 op = 6'b100000;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lbrd_before_reset", vec, V_LBRD);
    #2 reset = 1'b0;
    #1 chk("async_reset", vec, 19'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    run = 1'b1;
    run_instr(6'b000010, 6'b0);
    run_instr(6'b100000, 6'b0);
    wait_empty();
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Hard bound on total simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
